// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: FSM state encoding, IF/ID register layout and helpers.
package cpu_pkg;

  localparam int XLEN_C = 32;
  localparam logic [XLEN_C-1:0] NOP_INSTR_C = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN_C-1:0] pc;
    logic [XLEN_C-1:0] instr;
    logic [XLEN_C-1:0] pc_plus4;
  } if_id_t;

  // Instructions are word aligned; the two low address bits are forced to zero.
  function automatic logic [XLEN_C-1:0] align_word(input logic [XLEN_C-1:0] addr);
    return addr & ~{{(XLEN_C-2){1'b0}}, 2'b11};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry buffer that parks an instruction-memory response while decode is stalled.
module fetch_hold_buf
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_C
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  // Capture on load; clear (redirect or hand-off to IF/ID) takes priority.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      pc    <= {XLEN{1'b0}};
      instr <= {XLEN{1'b0}};
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else begin
      valid <= valid;
      pc    <= pc;
      instr <= instr;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem requests, IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_flushed counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              XLEN      = XLEN_C,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            id_stall,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_target,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};

  fetch_state_t    state_r, state_s;
  logic [XLEN-1:0] pc_r, pc_s;
  logic [XLEN-1:0] fetch_pc_r;
  if_id_t          if_id_r, if_id_s;
  logic            accept_s, rsp_s, req_s, if_id_load_s;
  logic            buf_load_s, buf_clear_s, buf_valid_s;
  logic [XLEN-1:0] buf_pc_s, buf_instr_s;

  assign accept_s    = !id_stall || !if_id_r.valid;
  assign rsp_s       = (state_r == WAIT) && imem_rvalid;
  assign req_s       = !rst && !ex_redirect && ((state_r == IDLE) || (rsp_s && accept_s));
  assign buf_load_s  = !ex_redirect && rsp_s && !accept_s;
  assign buf_clear_s = ex_redirect || ((state_r == HOLD) && accept_s);

  assign imem_req       = req_s;
  assign imem_addr      = pc_r;
  assign if_id_valid    = if_id_r.valid;
  assign if_id_pc       = if_id_r.pc;
  assign if_id_instr    = if_id_r.instr;
  assign if_id_pc_plus4 = if_id_r.pc_plus4;

  fetch_hold_buf #(
    .XLEN(XLEN)
  ) u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load_s),
    .clear     (buf_clear_s),
    .load_pc   (fetch_pc_r),
    .load_instr(imem_rdata),
    .valid     (buf_valid_s),
    .pc        (buf_pc_s),
    .instr     (buf_instr_s)
  );

  // Next-state: a redirect decides the outcome of whatever is in flight.
  always_comb begin
    state_s = state_r;
    if (ex_redirect) begin
      case (state_r)
        WAIT:    state_s = imem_rvalid ? IDLE : DROP;
        HOLD:    state_s = IDLE;
        default: state_s = state_r;
      endcase
    end else begin
      case (state_r)
        IDLE: state_s = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            state_s = accept_s ? WAIT : HOLD;
          end else begin
            state_s = WAIT;
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            state_s = IDLE;
          end else begin
            state_s = DROP;
          end
        end
        HOLD: begin
          if (accept_s && buf_valid_s) begin
            state_s = IDLE;
          end else begin
            state_s = HOLD;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // PC and IF/ID next values.
  always_comb begin
    pc_s          = pc_r;
    if_id_s       = if_id_r;
    if_id_load_s  = 1'b0;
    if (ex_redirect) begin
      pc_s = align_word(ex_target);
    end else if (req_s) begin
      pc_s = pc_r + PC_STEP;
    end else begin
      pc_s = pc_r;
    end

    if (ex_redirect) begin
      if_id_s.valid = 1'b0;
      if_id_s.instr = NOP_INSTR;
    end else if (rsp_s && accept_s) begin
      if_id_s      = '{valid: 1'b1, pc: fetch_pc_r, instr: imem_rdata,
                       pc_plus4: fetch_pc_r + PC_STEP};
      if_id_load_s = 1'b1;
    end else if ((state_r == HOLD) && buf_valid_s && accept_s) begin
      if_id_s      = '{valid: 1'b1, pc: buf_pc_s, instr: buf_instr_s,
                       pc_plus4: buf_pc_s + PC_STEP};
      if_id_load_s = 1'b1;
    end else if (id_stall && if_id_r.valid) begin
      if_id_s = if_id_r;
    end else begin
      if_id_s.valid = 1'b0;
      if_id_s.instr = NOP_INSTR;
    end
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      fetch_pc_r <= {XLEN{1'b0}};
      if_id_r    <= '{valid: 1'b0, pc: {XLEN{1'b0}}, instr: NOP_INSTR,
                      pc_plus4: {XLEN{1'b0}}};
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      fetch_pc_r <= req_s ? pc_r : fetch_pc_r;
      if_id_r    <= if_id_s;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic flush_hit_s;
  assign flush_hit_s = ex_redirect &&
                       (if_id_r.valid || (state_r == WAIT) || (state_r == HOLD));

  // Free-running, wrapping event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'd0;
      perf_flushed <= 32'd0;
    end else begin
      perf_fetched <= if_id_load_s ? perf_fetched + 32'd1 : perf_fetched;
      perf_flushed <= flush_hit_s ? perf_flushed + 32'd1 : perf_flushed;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, scoreboard-checked bench for fetch_stage with a 1-cycle instruction memory.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int NVEC = 27;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_rvalid, id_stall, ex_redirect, if_id_valid;
  logic [31:0] imem_addr, imem_rdata, ex_target, if_id_pc, if_id_instr, if_id_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  int checks = 0;
  int failures = 0;
  logic [95:0] exp_q[$];
  logic        mem_seen;
  logic [31:0] mem_addr;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        push;
  } vec_t;
  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN(32), .RESET_PC(32'h0000_0078), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  function automatic logic [31:0] memfn(input logic [31:0] a);
    logic [31:0] w;
    w = {16'hC0DE, a[15:0]};
    if (a == 32'h0000_0078) w = 32'h00b5_1463;
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // One-cycle memory: answers the request seen before the edge just after it.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      mem_seen = (imem_req === 1'b1);
      mem_addr = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = mem_seen;
      imem_rdata  = mem_seen ? memfn(mem_addr) : 32'h0;
    end
  end

  // Monitor: decode consumes IF/ID whenever valid and not stalled.
  initial begin
    logic [95:0] e;
    forever begin
      @(negedge clk);
      if (if_id_valid === 1'b1 && id_stall === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ifid_unexpected actual_pc=%h required=none", if_id_pc);
        end else begin
          e = exp_q.pop_front();
          check("ifid_pc", if_id_pc, e[95:64]);
          check("ifid_instr", if_id_instr, e[63:32]);
          check("ifid_pc_plus4", if_id_pc_plus4, e[31:0]);
        end
      end else if (if_id_valid !== 1'b1) begin
        check("ifid_nop", if_id_instr, NOP);
      end
    end
  end

  initial begin
    rst = 1'b1; id_stall = 1'b0; ex_redirect = 1'b0; ex_target = 32'h0;
    //            rst   stall redir tgt            req   addr           push
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0078, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_007C, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0080, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h0000_008C, 1'b0, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_008C, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0090, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0094, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0098, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0,         1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0104, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 32'h0000_0083, 1'b0, 32'h0,         1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0080, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0084, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b1};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b1};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b0};
    vecs[23] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[24] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0078, 1'b1};
    vecs[25] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_007C, 1'b0};
    vecs[26] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0080, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'b0, if_id_valid}, 32'd0);
    check("rst_pc", if_id_pc, 32'h0);
    check("rst_pc_plus4", if_id_pc_plus4, 32'h0);
    check("rst_instr", if_id_instr, NOP);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0000_0078);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_fetched", perf_fetched, 32'd0);
    check("rst_perf_flushed", perf_flushed, 32'd0);
`endif
    @(posedge clk);
    #1;

    for (int c = 0; c < NVEC; c++) begin
      rst         = vecs[c].rst;
      id_stall    = vecs[c].stall;
      ex_redirect = vecs[c].redir;
      ex_target   = vecs[c].tgt;
      if (vecs[c].push)
        exp_q.push_back({vecs[c].exp_addr, memfn(vecs[c].exp_addr),
                         vecs[c].exp_addr + 32'd4});
      @(negedge clk);
      check($sformatf("req_c%0d", c), {31'b0, imem_req}, {31'b0, vecs[c].exp_req});
      if (vecs[c].exp_req) check($sformatf("addr_c%0d", c), imem_addr, vecs[c].exp_addr);
      if (c == 4 || c == 14 || c == 17 || c == 24)
        check($sformatf("flushed_valid_c%0d", c), {31'b0, if_id_valid}, 32'd0);
      if (c == 7 || c == 8) begin
        check($sformatf("stall_hold_valid_c%0d", c), {31'b0, if_id_valid}, 32'd1);
        check($sformatf("stall_hold_pc_c%0d", c), if_id_pc, 32'h0000_008C);
      end
`ifdef FETCH_PERF_CNT_EN
      if (c == 23) begin
        check("perf_fetched_pre_rst", perf_fetched, 32'd9);
        check("perf_flushed_pre_rst", perf_flushed, 32'd4);
      end
      if (c == 26) begin
        check("perf_fetched_post_rst", perf_fetched, 32'd1);
        check("perf_flushed_post_rst", perf_flushed, 32'd0);
      end
`endif
      @(posedge clk);
      #1;
    end

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
